// File: rtl/snn_pkg.sv
// Shared types and helpers for the event-driven spiking core.
package snn_pkg;

  localparam int V_WIDTH_DEF = 16;
  localparam int W_WIDTH_DEF = 4;
  localparam int SPK_IDX_W   = 8;  // spike payload carries up to 256 neuron indices

  typedef logic signed [V_WIDTH_DEF-1:0] potential_t;
  typedef logic signed [W_WIDTH_DEF-1:0] weight_t;

  typedef struct packed {
    logic [15:0]          stamp;
    logic [SPK_IDX_W-1:0] neuron;
  } spike_t;

  typedef enum logic [1:0] {IDLE, ACCUM, UPDATE} state_t;

  // Signed add clamped to a 'width'-bit two's complement range.
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int width);
    logic signed [32:0] sum, hi, lo;
    sum = {a[31], a} + {b[31], b};
    hi  = (33'sd1 <<< (width - 1)) - 33'sd1;
    lo  = -hi - 33'sd1;
    if (sum > hi)      sat_add = hi[31:0];
    else if (sum < lo) sat_add = lo[31:0];
    else               sat_add = sum[31:0];
  endfunction

endpackage

// File: rtl/snn_spike_fifo.sv
// Synchronous FIFO with full/empty flags; simultaneous push and pop is honoured when full.
module snn_spike_fifo #(
  parameter int  DEPTH = 8,
  parameter type T     = logic [7:0]
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  T     wdata,
  output T     rdata,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);

  T           mem [DEPTH];
  logic [AW:0] wptr, rptr;
  logic        do_push, do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wptr[AW-1:0]] <= wdata;
        wptr              <= wptr + 1'b1;
      end
      if (do_pop) rptr <= rptr + 1'b1;
    end
  end

endmodule

// File: rtl/snn_event_core.sv
// Time-multiplexed spiking core: event accumulate, timestep leak/fire sweep, spike FIFO.
// Optional refractory counters enabled by SNN_EVENT_CORE_REFRACTORY_EN.
module snn_event_core
  import snn_pkg::*;
#(
  parameter int N_NEURONS        = 16,
  parameter int N_INPUTS         = 256,
  parameter int W_WIDTH          = 4,
  parameter int V_WIDTH          = 16,
  parameter int V_THRESH         = 256,
  parameter int V_RESET          = 0,
  parameter int LEAK_SHIFT       = 4,
  parameter int FIFO_DEPTH       = 8,
  parameter int REFRACTORY_STEPS = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         step,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [$clog2(N_INPUTS)-1:0]  in_index,
  input  logic                         wr_en,
  input  logic [$clog2(N_INPUTS)-1:0]  wr_row,
  input  logic [$clog2(N_NEURONS)-1:0] wr_neuron,
  input  logic [W_WIDTH-1:0]           wr_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(N_NEURONS)-1:0] out_index,
  output logic [15:0]                  out_time,
  output logic [15:0]                  timestep,
  output logic                         busy
);
  localparam int IW = $clog2(N_INPUTS);
  localparam int NW = $clog2(N_NEURONS);
  localparam logic signed [V_WIDTH-1:0] THRESH = V_WIDTH'(V_THRESH);
  localparam logic signed [V_WIDTH-1:0] V_RST  = V_WIDTH'(V_RESET);

  state_t state, state_nxt;
  logic [NW-1:0] n;
  logic [IW-1:0] row;
  logic          step_pending;

  logic [N_INPUTS-1:0][N_NEURONS-1:0][W_WIDTH-1:0] w;
  logic [N_NEURONS-1:0][V_WIDTH-1:0]               v;

  logic signed [V_WIDTH-1:0] v_cur, acc_v, lv, v_new;
  logic signed [W_WIDTH-1:0] w_cur;
  logic signed [31:0]        acc32;
  logic fire, last, refr_act;
  logic accept, adv, push, v_we, done;
  logic fifo_full, fifo_empty, pop;
  spike_t spike_in, head;
  logic unused_head;

  assign v_cur = v[n];
  assign w_cur = w[row][n];
  assign acc32 = sat_add(32'(v_cur), 32'(w_cur), V_WIDTH);
  assign acc_v = acc32[V_WIDTH-1:0];
  assign lv    = v_cur - (v_cur >>> LEAK_SHIFT);
  assign fire  = (lv >= THRESH);
  assign last  = (n == NW'(N_NEURONS - 1));

  assign in_ready  = (state == IDLE) && !step_pending;
  assign busy      = (state != IDLE) || step_pending;
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign spike_in  = {timestep, SPK_IDX_W'(n)};
  assign out_index = head.neuron[NW-1:0];
  assign out_time  = head.stamp;
  assign unused_head = ^head.neuron;

`ifdef SNN_EVENT_CORE_REFRACTORY_EN
  localparam int RW = $clog2(REFRACTORY_STEPS + 1);
  logic [N_NEURONS-1:0][RW-1:0] refr;

  assign refr_act = (refr[n] != '0);

  // Counters tick once per UPDATE visit; a stalled fire does not count as a visit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) refr <= '0;
    else if (state == UPDATE && adv) begin
      if (refr_act)  refr[n] <= refr[n] - 1'b1;
      else if (push) refr[n] <= RW'(REFRACTORY_STEPS);
    end
  end
`else
  logic unused_refr;
  assign refr_act    = 1'b0;
  assign unused_refr = ^32'(REFRACTORY_STEPS);
`endif

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    adv       = 1'b0;
    push      = 1'b0;
    v_we      = 1'b0;
    v_new     = v_cur;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (step_pending) state_nxt = UPDATE;
        else if (in_valid) begin
          accept    = 1'b1;
          state_nxt = ACCUM;
        end
      end
      ACCUM: begin
        adv   = 1'b1;
        v_we  = !refr_act;
        v_new = acc_v;
        if (last) state_nxt = IDLE;
      end
      UPDATE: begin
        if (fire && !refr_act) begin
          // Hold this neuron until the FIFO can take its spike.
          if (!fifo_full || pop) begin
            push  = 1'b1;
            adv   = 1'b1;
            v_we  = 1'b1;
            v_new = V_RST;
          end
        end else begin
          adv   = 1'b1;
          v_we  = !refr_act;
          v_new = lv;
        end
        if (adv && last) begin
          state_nxt = IDLE;
          done      = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      n            <= '0;
      row          <= '0;
      step_pending <= 1'b0;
      timestep     <= '0;
      v            <= {N_NEURONS{V_RST}};
    end else begin
      state <= state_nxt;
      if (adv)    n <= n + 1'b1;
      if (accept) row <= in_index;
      if (v_we)   v[n] <= v_new;
      step_pending <= done ? 1'b0 : (step_pending | step);
      if (done) timestep <= timestep + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) w <= '0;
    else if (wr_en) w[wr_row][wr_neuron] <= wr_data;
  end

  snn_spike_fifo #(
    .DEPTH(FIFO_DEPTH),
    .T    (spike_t)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .pop  (pop),
    .wdata(spike_in),
    .rdata(head),
    .full (fifo_full),
    .empty(fifo_empty)
  );

endmodule

// File: tb/tb_snn_event_core.sv
// Directed bench for snn_event_core: a default core plus an 8-bit-potential core sharing inputs.
module tb_snn_event_core;
  logic       clk = 1'b0, reset = 1'b1, step = 1'b0, in_valid = 1'b0, wr_en = 1'b0, out_ready = 1'b0;
  logic [7:0] in_index = '0, wr_row = '0;
  logic [3:0] wr_neuron = '0, wr_data = '0;
  logic       in_ready, out_valid, busy;
  logic [3:0] out_index;
  logic [15:0] out_time, timestep;
  logic       in_ready8, out_valid8, busy8;
  logic [3:0] out_index8;
  logic [15:0] out_time8, timestep8;
  int checks = 0, fails = 0;

  always #5 clk = ~clk;

  snn_event_core dut (
    .clk(clk), .reset(reset), .step(step), .in_valid(in_valid), .in_ready(in_ready),
    .in_index(in_index), .wr_en(wr_en), .wr_row(wr_row), .wr_neuron(wr_neuron),
    .wr_data(wr_data), .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index),
    .out_time(out_time), .timestep(timestep), .busy(busy)
  );

  snn_event_core #(.V_WIDTH(8), .V_THRESH(100)) dut8 (
    .clk(clk), .reset(reset), .step(step), .in_valid(in_valid), .in_ready(in_ready8),
    .in_index(in_index), .wr_en(wr_en), .wr_row(wr_row), .wr_neuron(wr_neuron),
    .wr_data(wr_data), .out_valid(out_valid8), .out_ready(out_ready), .out_index(out_index8),
    .out_time(out_time8), .timestep(timestep8), .busy(busy8)
  );

  // All tasks start and end just after a falling edge.
  task automatic do_reset();
    reset = 1'b1; step = 1'b0; in_valid = 1'b0; wr_en = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic write_w(input int r, input int c, input logic [3:0] d);
    wr_en = 1'b1; wr_row = 8'(r); wr_neuron = 4'(c); wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic pulse_step();
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
  endtask

  task automatic send_events(input int idx, input int cnt);
    int acc = 0, guard = 0;
    in_index = 8'(idx); in_valid = 1'b1;
    while (acc < cnt && guard < 5000) begin
      if (in_ready) acc++;
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b0;
    checks++; if (acc !== cnt) begin fails++; $display("FAIL send_events: accepted %0d required %0d", acc, cnt); end
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (busy && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL wait_idle: busy still %0b after %0d cycles", busy, cyc); end
  endtask

  task automatic test_reset();
    int cyc;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (timestep !== 16'd0) begin fails++; $display("FAIL reset_timestep: got %0d required 0", timestep); end
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %0b required 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %0b required 0", out_valid); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0b required 0", busy); end
    checks++; if (out_index !== 4'd0 || out_time !== 16'd0) begin fails++; $display("FAIL reset_head: got %0d/%0d required 0/0", out_index, out_time); end
    reset = 1'b0;
    @(negedge clk);
    pulse_step();
    wait_idle(cyc);
    checks++; if (cyc !== 17) begin fails++; $display("FAIL empty_step_len: got %0d required 17", cyc); end
    checks++; if (timestep !== 16'd1) begin fails++; $display("FAIL empty_step_ts: got %0d required 1", timestep); end
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL empty_step_spike: got %0b required 0", out_valid); end
  endtask

  task automatic test_fire();
    int cyc;
    do_reset();
    write_w(3, 5, 4'd7);
    send_events(3, 40);
    wait_idle(cyc);
    checks++; if ($signed(dut.v[5]) !== 16'sd280) begin fails++; $display("FAIL fire_v5_acc: got %0d required 280", $signed(dut.v[5])); end
    checks++; if ($signed(dut.v[4]) !== 16'sd0) begin fails++; $display("FAIL fire_v4_acc: got %0d required 0", $signed(dut.v[4])); end
    pulse_step();
    wait_idle(cyc);
    checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL fire_valid: got %0b required 1", out_valid); end
    checks++; if (out_index !== 4'd5) begin fails++; $display("FAIL fire_index: got %0d required 5", out_index); end
    checks++; if (out_time !== 16'd0) begin fails++; $display("FAIL fire_time: got %0d required 0", out_time); end
    checks++; if (timestep !== 16'd1) begin fails++; $display("FAIL fire_ts: got %0d required 1", timestep); end
    checks++; if ($signed(dut.v[5]) !== 16'sd0) begin fails++; $display("FAIL fire_v5_reset: got %0d required 0", $signed(dut.v[5])); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL fire_single: out_valid %0b required 0", out_valid); end
  endtask

  task automatic test_saturation();
    int cyc;
    do_reset();
    write_w(0, 2, 4'b1000);
    send_events(0, 20);
    wait_idle(cyc);
    checks++; if ($signed(dut8.v[2]) !== -8'sd128) begin fails++; $display("FAIL sat_v2: got %0d required -128", $signed(dut8.v[2])); end
    checks++; if ($signed(dut.v[2]) !== -16'sd160) begin fails++; $display("FAIL wide_v2: got %0d required -160", $signed(dut.v[2])); end
    pulse_step();
    wait_idle(cyc);
    checks++; if ($signed(dut8.v[2]) !== -8'sd120) begin fails++; $display("FAIL sat_leak: got %0d required -120", $signed(dut8.v[2])); end
    checks++; if ($signed(dut.v[2]) !== -16'sd150) begin fails++; $display("FAIL wide_leak: got %0d required -150", $signed(dut.v[2])); end
    checks++; if (out_valid8 !== 1'b0 || out_valid !== 1'b0) begin fails++; $display("FAIL sat_nospike: got %0b/%0b required 0/0", out_valid8, out_valid); end
    checks++; if (busy8 !== 1'b0 || in_ready8 !== 1'b1 || timestep8 !== 16'd1) begin fails++; $display("FAIL sat_idle: busy %0b rdy %0b ts %0d required 0 1 1", busy8, in_ready8, timestep8); end
    checks++; if (out_index8 !== 4'd0 || out_time8 !== 16'd0) begin fails++; $display("FAIL sat_head: got %0d/%0d required 0/0", out_index8, out_time8); end
  endtask

  task automatic test_backpressure();
    int cyc, got = 0, guard = 0;
    do_reset();
    for (int i = 0; i < 16; i++) write_w(0, i, 4'd7);
    send_events(0, 40);
    wait_idle(cyc);
    pulse_step();
    repeat (20) @(negedge clk);
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL bp_busy: got %0b required 1", busy); end
    checks++; if (dut.n !== 4'd8) begin fails++; $display("FAIL bp_stall_n: got %0d required 8", dut.n); end
    checks++; if (out_valid !== 1'b1 || out_index !== 4'd0) begin fails++; $display("FAIL bp_head: valid %0b index %0d required 1 0", out_valid, out_index); end
    out_ready = 1'b1;
    while (got < 16 && guard < 200) begin
      if (out_valid) begin
        checks++; if (out_index !== 4'(got) || out_time !== 16'd0) begin fails++; $display("FAIL bp_order: got %0d@%0d required %0d@0", out_index, out_time, got); end
        got++;
      end
      @(negedge clk);
      guard++;
    end
    out_ready = 1'b0;
    checks++; if (got !== 16) begin fails++; $display("FAIL bp_count: got %0d required 16", got); end
    wait_idle(cyc);
    checks++; if (timestep !== 16'd1 || out_valid !== 1'b0) begin fails++; $display("FAIL bp_end: ts %0d valid %0b required 1 0", timestep, out_valid); end
  endtask

  task automatic test_priority();
    int cyc, guard = 0;
    do_reset();
    write_w(1, 0, 4'd1);
    in_index = 8'd1; in_valid = 1'b1;
    @(negedge clk);
    repeat (3) @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL prio_accum_ready: got %0b required 0", in_ready); end
    pulse_step();
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    checks++; if (timestep !== 16'd1) begin fails++; $display("FAIL prio_ts: got %0d required 1 when event re-accepted", timestep); end
    checks++; if ($signed(dut.v[0]) !== 16'sd1) begin fails++; $display("FAIL prio_v0_mid: got %0d required 1", $signed(dut.v[0])); end
    @(negedge clk);
    in_valid = 1'b0;
    wait_idle(cyc);
    checks++; if ($signed(dut.v[0]) !== 16'sd2 || timestep !== 16'd1) begin fails++; $display("FAIL prio_end: v0 %0d ts %0d required 2 1", $signed(dut.v[0]), timestep); end
  endtask

  task automatic test_reset_mid();
    int cyc;
    do_reset();
    for (int i = 0; i < 3; i++) write_w(0, i, 4'd7);
    send_events(0, 40);
    wait_idle(cyc);
    pulse_step();
    repeat (8) @(negedge clk);
    checks++; if (busy !== 1'b1 || out_valid !== 1'b1) begin fails++; $display("FAIL mid_pre: busy %0b valid %0b required 1 1", busy, out_valid); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || timestep !== 16'd0) begin fails++; $display("FAIL mid_flush: valid %0b ts %0d required 0 0", out_valid, timestep); end
    checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL mid_idle: busy %0b rdy %0b required 0 1", busy, in_ready); end
    checks++; if ($signed(dut.v[2]) !== 16'sd0) begin fails++; $display("FAIL mid_v: got %0d required 0", $signed(dut.v[2])); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_fire();
    test_saturation();
    test_backpressure();
    test_priority();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
